// File: rtl/fetch_pkg.sv
// Shared types and constants for the mainmem instruction-fetch unit.
package fetch_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [31:0] DEF_STARTING_ADDR   = 32'h0100_0000;
  localparam logic [31:0] DEF_MEM_DEPTH_BYTES = 32'h0010_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    HOLD  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} entries; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    full    = (count == DEPTH_C);
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator for mainmem with stall, redirect and end-of-memory stop.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] STARTING_ADDR   = DEF_STARTING_ADDR,
  parameter logic [31:0] MEM_DEPTH_BYTES = DEF_MEM_DEPTH_BYTES,
  parameter int unsigned FIFO_DEPTH      = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  input  logic [31:0] mem_data_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fault
`endif
);

  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] LAST_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [31:0]   target;
  logic          misaligned;
  logic          in_range;
  logic          redir_take;
  logic          pop;
  logic          fetch;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = |redirect_pc[1:0];
  assign target     = redirect_pc;
`else
  assign misaligned = 1'b0;
  assign target     = redirect_pc & ~32'd3;
`endif

  always_comb begin
    in_range   = (target >= STARTING_ADDR) && (target <= LAST_ADDR);
    redir_take = redirect_valid && (state == RUN || state == HOLD || state == DONE);
    pop        = inst_valid && inst_ready;
    fetch      = (state == RUN) && !halt && !redirect_valid && (!fifo_full || pop);
    push_entry = '{pc: pc, inst: mem_data_out};
  end

  assign mem_address    = pc;
  assign mem_data_in    = '0;
  assign mem_read_write = READ;
  assign inst_valid     = !fifo_empty;
  assign inst           = head.inst;
  assign inst_pc        = head.pc;

  // Redirect always wins; an in-range redirect under halt parks in HOLD at the new pc.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= STARTING_ADDR;
    end else if (redir_take) begin
      pc <= target;
      if (misaligned)     state <= FAULT;
      else if (!in_range) state <= DONE;
      else if (halt)      state <= HOLD;
      else                state <= RUN;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          pc    <= STARTING_ADDR;
        end
        RUN: begin
          if (halt) state <= HOLD;
          else if (fetch) begin
            if (pc == LAST_ADDR) state <= DONE;
            else                 pc    <= pc + 32'd4;
          end
        end
        HOLD:    if (!halt) state <= RUN;
        default: ;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clock) begin
    if (!reset_n)                      fault <= 1'b0;
    else if (redir_take && misaligned) fault <= 1'b1;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset_n) assert (fifo_count <= CW'(FIFO_DEPTH));
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (redir_take),
    .push    (fetch),
    .pop     (pop),
    .din     (push_entry),
    .dout    (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a combinational preloaded memory (word k = 'h13+k).
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_read_write;
  logic [31:0] mem_data_out;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fault;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clock = ~clock;

  assign mem_data_out = 32'h13 + ((mem_address - 32'h0100_0000) >> 2);

  fetch_unit #(
    .STARTING_ADDR   (32'h0100_0000),
    .MEM_DEPTH_BYTES (32'h0010_0000),
    .FIFO_DEPTH      (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_read_write (mem_read_write),
    .mem_data_out   (mem_data_out),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fault          (fault)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_pc    = target;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h13 + ((a - 32'h0100_0000) >> 2);
  endfunction

  initial begin
    start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; inst_ready = 1'b0;
    #2;
    do_reset();

    check("rst_addr",  mem_address, 32'h0100_0000);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst",  inst, 32'd0);
    check("rst_pc",    inst_pc, 32'd0);
    check("rst_rw",    {31'd0, mem_read_write}, 32'd0);
    check("rst_din",   mem_data_in, 32'd0);
    check("rst_count", 32'(dut.u_fifo.count), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));

    // redirect is ignored while idle
    redirect(32'h0100_0100);
    check("idle_redir_state", 32'(dut.state), 32'(IDLE));
    check("idle_redir_addr",  mem_address, 32'h0100_0000);

    // start with decode always ready
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_t_valid", {31'd0, inst_valid}, 32'd0);
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      check("stream_valid", {31'd0, inst_valid}, 32'd1);
      check("stream_pc",    inst_pc, 32'h0100_0000 + 4 * k);
      check("stream_inst",  inst, word_at(32'h0100_0000 + 4 * k));
    end

    // backpressure from a fresh start
    do_reset();
    inst_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned k = 0; k < 5; k++) tick();
    check("bp_count", 32'(dut.u_fifo.count), 32'd2);
    check("bp_addr",  mem_address, 32'h0100_0008);
    check("bp_head",  inst_pc, 32'h0100_0000);
    inst_ready = 1'b1;
    for (int unsigned k = 1; k < 4; k++) begin
      tick();
      check("bp_resume_pc",   inst_pc, 32'h0100_0000 + 4 * k);
      check("bp_resume_inst", inst, word_at(32'h0100_0000 + 4 * k));
    end

    // redirect while full (same-cycle pop discarded)
    inst_ready = 1'b0;
    tick();
    check("full_count", 32'(dut.u_fifo.count), 32'd2);
    check("full_addr",  mem_address, 32'h0100_0014);
    inst_ready = 1'b1;
    redirect(32'h0100_0100);
    check("redir_valid", {31'd0, inst_valid}, 32'd0);
    check("redir_addr",  mem_address, 32'h0100_0100);
    tick();
    check("redir_pc0",   inst_pc, 32'h0100_0100);
    check("redir_inst0", inst, 32'h53);
    tick();
    check("redir_pc1",   inst_pc, 32'h0100_0104);
    check("redir_inst1", inst, 32'h54);

    // halt together with redirect
    halt = 1'b1;
    redirect(32'h0100_0200);
    check("hr_state", 32'(dut.state), 32'(HOLD));
    check("hr_addr",  mem_address, 32'h0100_0200);
    check("hr_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    tick();
    check("hr_hold_count", 32'(dut.u_fifo.count), 32'd0);
    check("hr_hold_addr",  mem_address, 32'h0100_0200);
    halt = 1'b0;
    tick();
    check("hr_run_state", 32'(dut.state), 32'(RUN));
    check("hr_run_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    check("hr_pc",   inst_pc, 32'h0100_0200);
    check("hr_inst", inst, 32'h93);

    // end of memory
    redirect(32'h010F_FFF8);
    check("eom_valid0", {31'd0, inst_valid}, 32'd0);
    tick();
    check("eom_pc0",   inst_pc, 32'h010F_FFF8);
    check("eom_inst0", inst, 32'h0004_0011);
    tick();
    check("eom_pc1",   inst_pc, 32'h010F_FFFC);
    check("eom_inst1", inst, 32'h0004_0012);
    check("eom_state", 32'(dut.state), 32'(DONE));
    tick();
    tick();
    check("eom_drained", {31'd0, inst_valid}, 32'd0);
    check("eom_addr",    mem_address, 32'h010F_FFFC);

    // out-of-range redirect stays DONE without fetching
    redirect(32'h0200_0000);
    check("oor_state", 32'(dut.state), 32'(DONE));
    tick();
    check("oor_valid", {31'd0, inst_valid}, 32'd0);

    // misaligned redirect
    redirect(32'h0100_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_state", 32'(dut.state), 32'(FAULT));
    check("mis_addr",  mem_address, 32'h0100_0102);
    tick();
    tick();
    check("mis_valid",      {31'd0, inst_valid}, 32'd0);
    check("mis_fault_hold", {31'd0, fault}, 32'd1);
`else
    check("mis_addr",  mem_address, 32'h0100_0100);
    check("mis_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    check("mis_pc",   inst_pc, 32'h0100_0100);
    check("mis_inst", inst, 32'h53);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
